// File: rtl/display5461_monitor.sv
// display5461_monitor: receive-side decoder for the scanned 4-digit
// 7-segment bus; rebuilds hex frames, decimal points and liveness.
module display5461_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 65535,
  parameter logic        SEG_ON        = 1'b1,
  parameter logic        DIG_ON        = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  segments,
  input  logic [3:0]  digits,
  output logic [15:0] hexx,
  output logic [3:0]  points,
  output logic        frame_valid,
  output logic        decode_err,
  output logic        stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [15:0] TO_MAX = 16'(TIMEOUT);

  logic [7:0]    seg;
  logic [3:0]    sel;
  logic [11:0]   prev;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          armed;
  logic          armed_next;
  logic [3:0]    mask;
  logic [3:0]    mask_next;
  logic [3:0]    dp_sh;
  logic [15:0]   nib_sh;
  logic [15:0]   tcnt;
  logic          cand;
  logic          same;
  logic          arm_eff;
  logic          accept;
  logic          ok;
  logic          flush;
  logic          hit;
  logic [4:0]    dec;
  logic [1:0]    idx;

  // {valid, nibble} for a gfedcba pattern
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  assign dec = decode(seg[6:0]);

  always_comb begin
    idx = 2'd0;
    case (sel)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  always_comb begin
    cand = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0)
        && (seg[6:0] != 7'd0);
    same = cand && ({sel, seg} == prev) && (cnt != '0);
    // a changed candidate re-arms even without an idle gap
    arm_eff = armed || !same;
    if (!cand) cnt_next = '0;
    else if (!same) cnt_next = CW'(1);
    else if (cnt == CNT_MAX) cnt_next = cnt;
    else cnt_next = cnt + 1'b1;
    accept = cand && (cnt_next == CNT_MAX) && arm_eff;
    armed_next = !cand || (arm_eff && !accept);
    ok = accept && dec[4];
    flush = (mask == 4'hF);
    mask_next = flush ? 4'h0 : mask;
    if (ok) mask_next[idx] = 1'b1;
    hit = !ok && (tcnt == TO_MAX - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg         <= '0;
      sel         <= '0;
      prev        <= '0;
      cnt         <= '0;
      armed       <= 1'b1;
      mask        <= '0;
      nib_sh      <= '0;
      dp_sh       <= '0;
      tcnt        <= '0;
      hexx        <= '0;
      points      <= '0;
      frame_valid <= 1'b0;
      decode_err  <= 1'b0;
      stale       <= 1'b1;
    end else begin
      seg         <= segments ^ {8{~SEG_ON}};
      sel         <= digits ^ {4{~DIG_ON}};
      prev        <= {sel, seg};
      cnt         <= cnt_next;
      armed       <= armed_next;
      mask        <= mask_next;
      frame_valid <= flush;
      decode_err  <= accept && !dec[4];
      if (ok) begin
        nib_sh[{idx, 2'b00} +: 4] <= dec[3:0];
        dp_sh[idx] <= seg[7];
      end
      if (flush) begin
        hexx   <= nib_sh;
        points <= dp_sh;
      end
      if (ok) tcnt <= '0;
      else if (tcnt != TO_MAX) tcnt <= tcnt + 16'd1;
      if (flush) stale <= 1'b0;
      if (hit) stale <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display5461_monitor.sv
// tb_display5461_monitor: scenario tasks plus a run-length based
// reference model of the display bus decoder.
module tb_display5461_monitor;

  localparam int SC = 4;
  localparam int TO = 300;

  typedef struct {
    int         c;
    logic [15:0] h;
    logic [3:0]  p;
    logic        s;
  } frm_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  segments = 8'h00;
  logic [3:0]  digits = 4'hF;
  logic [15:0] hexx;
  logic [3:0]  points;
  logic        frame_valid;
  logic        decode_err;
  logic        stale;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  frm_t fq[$];
  frm_t exp_fq[$];
  logic [11:0] stim[$];
  int stim_c[$];
  int errs = 0;
  int err_hi = 0;
  int exp_errs = 0;
  int sneaky = 0;
  int stale_rise_c = -1;
  int stale_fall_c = -1;
  logic [15:0] last_h = '0;
  logic [3:0]  last_p = '0;
  logic        last_de = 1'b0;
  logic        last_st = 1'b1;

  display5461_monitor #(
    .STABLE_CYCLES(SC),
    .TIMEOUT(TO),
    .SEG_ON(1'b1),
    .DIG_ON(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .segments(segments),
    .digits(digits),
    .hexx(hexx),
    .points(points),
    .frame_valid(frame_valid),
    .decode_err(decode_err),
    .stale(stale)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_valid === 1'b1) fq.push_back('{cyc, hexx, points, stale});
      else if (hexx !== last_h || points !== last_p) sneaky++;
      if (decode_err === 1'b1) begin
        err_hi++;
        if (last_de !== 1'b1) errs++;
      end
      if (stale === 1'b1 && last_st === 1'b0) stale_rise_c = cyc;
      if (stale === 1'b0 && last_st === 1'b1) stale_fall_c = cyc;
    end
    last_h = hexx;
    last_p = points;
    last_de = decode_err;
    last_st = stale;
  end

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
  endfunction

  function automatic int lookup(input logic [6:0] p);
    lookup = -1;
    for (int k = 0; k < 16; k++)
      if (pat(4'(k)) == p) lookup = k;
  endfunction

  function automatic logic [7:0] dseg(input logic [3:0] n, input logic dp);
    dseg = {dp, pat(n)};
  endfunction

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    digits = 4'hF;
    segments = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fq.delete();
    stim.delete();
    stim_c.delete();
    errs = 0;
    err_hi = 0;
  endtask

  // one call = n consecutive cycles of the same bus sample
  task automatic drive(input logic [3:0] sel, input logic [7:0] seg, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      digits = ~sel;
      segments = seg;
      stim.push_back({sel, seg});
      stim_c.push_back(cyc);
    end
  endtask

  task automatic scan(input logic [15:0] v, input logic [3:0] p, input int n);
    for (int d = 3; d >= 0; d--)
      drive(4'(1 << d), dseg(v[d*4 +: 4], p[d]), n);
  endtask

  // Each run of >= SC identical one-hot, non-blank samples is one accept,
  // taking effect SC+1 cycles after the run's first drive.
  task automatic run_model();
    logic [3:0]  msk;
    logic [15:0] sh;
    logic [3:0]  dp;
    int i;
    int j;
    int a;
    int d;
    int nib;
    msk = 4'h0;
    sh = 16'h0;
    dp = 4'h0;
    exp_fq.delete();
    exp_errs = 0;
    i = 0;
    while (i < stim.size()) begin
      j = i;
      while (j + 1 < stim.size() && stim[j+1] == stim[i]) j++;
      if ($countones(stim[i][11:8]) == 1 && stim[i][6:0] != 7'd0
          && (j - i + 1) >= SC) begin
        a = stim_c[i] + SC + 1;
        d = $clog2(stim[i][11:8]);
        nib = lookup(stim[i][6:0]);
        if (nib < 0) exp_errs++;
        else begin
          sh[d*4 +: 4] = nib[3:0];
          dp[d] = stim[i][7];
          msk[d] = 1'b1;
          if (msk == 4'hF) begin
            exp_fq.push_back('{a + 1, sh, dp, 1'b0});
            msk = 4'h0;
          end
        end
      end
      i = j + 1;
    end
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    total++;
    if (hexx !== 16'h0) begin bad++; $display("FAIL reset_hexx got=%h want=0000", hexx); end
    total++;
    if (points !== 4'h0) begin bad++; $display("FAIL reset_points got=%b want=0000", points); end
    total++;
    if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b want=0", frame_valid); end
    total++;
    if (decode_err !== 1'b0) begin bad++; $display("FAIL reset_derr got=%b want=0", decode_err); end
    total++;
    if (stale !== 1'b1) begin bad++; $display("FAIL reset_stale got=%b want=1", stale); end
  endtask

  task automatic test_scan();
    reset_dut();
    repeat (3) scan(16'h1234, 4'b0100, 8);
    drive(4'h0, 8'h00, 10);
    run_model();
    total++;
    if (fq.size() !== 3) begin bad++; $display("FAIL scan_count got=%0d want=3", fq.size()); end
    for (int k = 0; k < fq.size(); k++) begin
      total++;
      if (fq[k].h !== 16'h1234 || fq[k].p !== 4'b0100) begin
        bad++;
        $display("FAIL scan_frame%0d got=%h/%b want=1234/0100", k, fq[k].h, fq[k].p);
      end
    end
    if (fq.size() > 0) begin
      total++;
      if (fq[0].c !== stim_c[24] + SC + 2) begin
        bad++;
        $display("FAIL scan_latency got=%0d want=%0d", fq[0].c, stim_c[24] + SC + 2);
      end
    end
    total++;
    if (fq.size() !== exp_fq.size()) begin
      bad++;
      $display("FAIL scan_model_count got=%0d want=%0d", fq.size(), exp_fq.size());
    end
    for (int k = 0; k < fq.size() && k < exp_fq.size(); k++) begin
      total++;
      if (fq[k].c !== exp_fq[k].c || fq[k].h !== exp_fq[k].h) begin
        bad++;
        $display("FAIL scan_model%0d got=%0d/%h want=%0d/%h", k, fq[k].c, fq[k].h,
                 exp_fq[k].c, exp_fq[k].h);
      end
    end
  endtask

  task automatic test_glitch();
    reset_dut();
    repeat (2) begin
      drive(4'b1000, dseg(4'h1, 1'b0), 8);
      drive(4'b0100, dseg(4'h2, 1'b1), 8);
      drive(4'b0010, dseg(4'h3, 1'b0), 8);
      drive(4'b0100, dseg(4'h9, 1'b0), SC - 1);
      drive(4'b0001, dseg(4'h4, 1'b0), 8);
    end
    drive(4'h0, 8'h00, 8);
    total++;
    if (fq.size() !== 2) begin bad++; $display("FAIL glitch_count got=%0d want=2", fq.size()); end
    for (int k = 0; k < fq.size(); k++) begin
      total++;
      if (fq[k].h !== 16'h1234 || fq[k].p !== 4'b0100) begin
        bad++;
        $display("FAIL glitch_frame%0d got=%h/%b want=1234/0100", k, fq[k].h, fq[k].p);
      end
    end
  endtask

  task automatic test_ignore();
    reset_dut();
    drive(4'b1000, dseg(4'h1, 1'b0), 6);
    drive(4'b1000, 8'h00, 2);
    drive(4'b0011, dseg(4'h8, 1'b0), 6);
    drive(4'b0100, dseg(4'h2, 1'b1), 6);
    drive(4'b0100, 8'h80, 2);
    drive(4'b0010, dseg(4'h3, 1'b0), 6);
    drive(4'b1100, dseg(4'h8, 1'b0), 6);
    drive(4'b0000, dseg(4'h8, 1'b0), 3);
    drive(4'b0001, dseg(4'h4, 1'b0), 6);
    drive(4'h0, 8'h00, 6);
    total++;
    if (fq.size() !== 1) begin bad++; $display("FAIL ignore_count got=%0d want=1", fq.size()); end
    if (fq.size() > 0) begin
      total++;
      if (fq[0].h !== 16'h1234 || fq[0].p !== 4'b0100) begin
        bad++;
        $display("FAIL ignore_frame got=%h/%b want=1234/0100", fq[0].h, fq[0].p);
      end
    end
  endtask

  task automatic test_bad_pattern();
    reset_dut();
    drive(4'b1000, dseg(4'h5, 1'b0), 8);
    drive(4'b0100, dseg(4'h6, 1'b0), 8);
    drive(4'b0010, dseg(4'h7, 1'b0), 8);
    drive(4'b0001, 8'h55, 10);
    drive(4'h0, 8'h00, 6);
    total++;
    if (errs !== 1) begin bad++; $display("FAIL bad_err_count got=%0d want=1", errs); end
    total++;
    if (err_hi !== 1) begin bad++; $display("FAIL bad_err_width got=%0d want=1", err_hi); end
    total++;
    if (fq.size() !== 0) begin bad++; $display("FAIL bad_no_frame got=%0d want=0", fq.size()); end
    drive(4'b0001, dseg(4'h8, 1'b1), 8);
    drive(4'h0, 8'h00, 6);
    total++;
    if (fq.size() !== 1) begin bad++; $display("FAIL bad_resume_count got=%0d want=1", fq.size()); end
    if (fq.size() > 0) begin
      total++;
      if (fq[0].h !== 16'h5678 || fq[0].p !== 4'b0001) begin
        bad++;
        $display("FAIL bad_resume_frame got=%h/%b want=5678/0001", fq[0].h, fq[0].p);
      end
    end
  endtask

  task automatic test_stale();
    int fv_c;
    reset_dut();
    stale_rise_c = -1;
    stale_fall_c = -1;
    drive(4'b1000, dseg(4'h1, 1'b0), 8);
    drive(4'b0100, dseg(4'h2, 1'b1), 8);
    drive(4'b0010, dseg(4'h3, 1'b0), 8);
    drive(4'b0001, dseg(4'h4, 1'b0), 50);
    drive(4'h0, 8'h00, TO + 10);
    total++;
    if (fq.size() !== 1) begin bad++; $display("FAIL stale_frame_count got=%0d want=1", fq.size()); end
    fv_c = (fq.size() > 0) ? fq[0].c : -1000;
    total++;
    if (stale_rise_c !== fv_c + TO - 1) begin
      bad++;
      $display("FAIL stale_rise got=%0d want=%0d", stale_rise_c, fv_c + TO - 1);
    end
    total++;
    if (stale !== 1'b1) begin bad++; $display("FAIL stale_level got=%b want=1", stale); end
    scan(16'hABCD, 4'b0000, 8);
    drive(4'h0, 8'h00, 6);
    total++;
    if (fq.size() !== 2) begin bad++; $display("FAIL stale_resume_count got=%0d want=2", fq.size()); end
    if (fq.size() > 1) begin
      total++;
      if (stale_fall_c !== fq[1].c) begin
        bad++;
        $display("FAIL stale_fall got=%0d want=%0d", stale_fall_c, fq[1].c);
      end
    end
    total++;
    if (stale !== 1'b0) begin bad++; $display("FAIL stale_cleared got=%b want=0", stale); end
  endtask

  task automatic test_mid_reset();
    reset_dut();
    drive(4'b1000, dseg(4'h1, 1'b1), 8);
    drive(4'b0100, dseg(4'h2, 1'b1), 8);
    drive(4'h0, 8'h00, 4);
    total++;
    if (fq.size() !== 0) begin bad++; $display("FAIL midrst_partial got=%0d want=0", fq.size()); end
    reset_dut();
    drive(4'b0010, dseg(4'hC, 1'b0), 8);
    drive(4'b0001, dseg(4'hD, 1'b0), 8);
    drive(4'b1000, dseg(4'hA, 1'b0), 8);
    drive(4'b0100, dseg(4'hB, 1'b0), 8);
    drive(4'h0, 8'h00, 6);
    total++;
    if (fq.size() !== 1) begin bad++; $display("FAIL midrst_count got=%0d want=1", fq.size()); end
    if (fq.size() > 0) begin
      total++;
      if (fq[0].h !== 16'hABCD || fq[0].p !== 4'b0000) begin
        bad++;
        $display("FAIL midrst_frame got=%h/%b want=ABCD/0000", fq[0].h, fq[0].p);
      end
    end
  endtask

  task automatic test_random();
    int pos;
    int r;
    int n;
    int p;
    logic [3:0] sel;
    logic [7:0] seg;
    for (int round = 0; round < 4; round++) begin
      reset_dut();
      pos = 0;
      for (int it = 0; it < 80; it++) begin
        r = $urandom_range(0, 9);
        if (r < 6) begin
          if ($urandom_range(0, 4) != 0) pos = (pos + 3) % 4;
          else pos = $urandom_range(0, 3);
          sel = 4'(1 << pos);
          seg = dseg(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
          n = $urandom_range(2, 9);
        end else if (r == 6) begin
          sel = 4'(1 << $urandom_range(0, 3));
          seg = {1'($urandom_range(0, 1)), 7'h00};
          n = $urandom_range(1, 3);
        end else if (r == 7) begin
          sel = 4'($urandom_range(0, 15));
          if ($countones(sel) == 1) sel = 4'hC;
          seg = dseg(4'($urandom_range(0, 15)), 1'b0);
          n = $urandom_range(1, 8);
        end else begin
          p = $urandom_range(1, 127);
          while (lookup(7'(p)) >= 0) p = $urandom_range(1, 127);
          sel = 4'(1 << $urandom_range(0, 3));
          seg = {1'b0, 7'(p)};
          n = $urandom_range(1, 8);
        end
        drive(sel, seg, n);
      end
      drive(4'h0, 8'h00, 12);
      run_model();
      total++;
      if (fq.size() !== exp_fq.size()) begin
        bad++;
        $display("FAIL rand%0d_count got=%0d want=%0d", round, fq.size(), exp_fq.size());
      end
      for (int k = 0; k < fq.size() && k < exp_fq.size(); k++) begin
        total++;
        if (fq[k].c !== exp_fq[k].c || fq[k].h !== exp_fq[k].h || fq[k].p !== exp_fq[k].p) begin
          bad++;
          $display("FAIL rand%0d_frame%0d got=%0d/%h/%b want=%0d/%h/%b", round, k,
                   fq[k].c, fq[k].h, fq[k].p, exp_fq[k].c, exp_fq[k].h, exp_fq[k].p);
        end
      end
      total++;
      if (errs !== exp_errs || err_hi !== exp_errs) begin
        bad++;
        $display("FAIL rand%0d_derr got=%0d/%0d want=%0d", round, errs, err_hi, exp_errs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_glitch();
    test_ignore();
    test_bad_pattern();
    test_stale();
    test_mid_reset();
    test_random();
    total++;
    if (sneaky !== 0) begin bad++; $display("FAIL hold_between_frames got=%0d want=0", sneaky); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
